// File: rtl/fp_pkg.sv
// Shared types and helpers for the packed-float utilities: FSM states, result
// flags, input classes and the IEEE754 single-precision layout.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } fp_state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [2:0] {
    CLS_NAN,
    CLS_INF,
    CLS_ZERO,
    CLS_TINY,
    CLS_MINNEG,
    CLS_OVF,
    CLS_NORMAL
  } fp_class_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } ieee754_sp_t;

  function automatic int exp_offset(input int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier: packed float -> class, alignment shift count and
// shift direction (dir=1 means shift the significand left).
module fp_classify
  import fp_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23,
  parameter int NI = 32,
  parameter int KW = 6
) (
  input  logic [NX+NM:0] data,
  output fp_class_t      cls,
  output logic [KW-1:0]  k,
  output logic           dir
);

  localparam int XOFF = exp_offset(NX);
  localparam logic [NX-1:0] EXP_MAX = '1;

  logic          sign;
  logic [NX-1:0] expo;
  logic [NM-1:0] mant;
  int            ue;

  assign sign = data[NX+NM];
  assign expo = data[NX+NM-1:NM];
  assign mant = data[NM-1:0];
  assign ue   = int'(expo) - XOFF;

  always_comb begin
    cls = CLS_NORMAL;
    k   = '0;
    dir = 1'b0;
    if (expo == EXP_MAX) begin
      cls = (mant != '0) ? CLS_NAN : CLS_INF;
    end else if (expo == '0) begin
      cls = CLS_ZERO;
    end else if (ue < 0) begin
      cls = CLS_TINY;
    end else if (ue == NI - 1 && sign && mant == '0) begin
      cls = CLS_MINNEG;
    end else if (ue >= NI - 1) begin
      cls = CLS_OVF;
    end else if (ue > NM) begin
      dir = 1'b1;
      k   = KW'(ue - NM);
    end else begin
      k   = KW'(NM - ue);
    end
  end

endmodule

// File: rtl/fp_to_int_seq.sv
// Sequential float-to-signed-integer converter, round toward zero. The
// significand is aligned one bit per cycle with valid/ready on both sides.
module fp_to_int_seq
  import fp_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23,
  parameter int NI = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NX+NM:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NI-1:0]   out_data,
  output logic [2:0]      out_flags
);

  localparam int W  = (NM + 1 > NI) ? NM + 1 : NI;
  localparam int KW = $clog2(W + 1);
  localparam logic [NI-1:0] INT_MAX = {1'b0, {(NI-1){1'b1}}};
  localparam logic [NI-1:0] INT_MIN = {1'b1, {(NI-1){1'b0}}};

  fp_state_t     state_reg, state_next;
  logic [W-1:0]  work_reg;
  logic [KW-1:0] k_reg;
  logic          dir_reg;
  logic          sign_reg;
  logic          sticky_reg;
  logic [NI-1:0] out_data_reg;
  fp_flags_t     flags_reg;

  fp_class_t     cls;
  logic [KW-1:0] k_in;
  logic          dir_in;
  logic          sign_in;
  logic [W-1:0]  sig_in;
  logic [NI-1:0] idle_res;
  logic [W-1:0]  work_shift;
  logic          sticky_next;
  logic [NI-1:0] shift_res;

  fp_classify #(.NX(NX), .NM(NM), .NI(NI), .KW(KW)) u_classify (
    .data (in_data),
    .cls  (cls),
    .k    (k_in),
    .dir  (dir_in)
  );

  // Magnitude always fits in NI-1 bits for normal inputs, so negation is safe.
  always_comb begin
    sign_in     = in_data[NX+NM];
    sig_in      = W'({1'b1, in_data[NM-1:0]});
    idle_res    = sign_in ? (~sig_in[NI-1:0] + NI'(1)) : sig_in[NI-1:0];
    work_shift  = dir_reg ? (work_reg << 1) : (work_reg >> 1);
    sticky_next = sticky_reg | (~dir_reg & work_reg[0]);
    shift_res   = sign_reg ? (~work_shift[NI-1:0] + NI'(1)) : work_shift[NI-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (in_valid) state_next = (cls == CLS_NORMAL && k_in != '0) ? SHIFT : DONE;
      SHIFT: if (k_reg == KW'(1)) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg     <= '0;
      k_reg        <= '0;
      dir_reg      <= 1'b0;
      sign_reg     <= 1'b0;
      sticky_reg   <= 1'b0;
      out_data_reg <= '0;
      flags_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          sign_reg   <= sign_in;
          sticky_reg <= 1'b0;
          flags_reg  <= '0;
          case (cls)
            CLS_NAN: begin
              out_data_reg      <= '0;
              flags_reg.invalid <= 1'b1;
            end
            CLS_INF: begin
              out_data_reg      <= sign_in ? INT_MIN : INT_MAX;
              flags_reg.invalid <= 1'b1;
            end
            CLS_ZERO: begin
              out_data_reg      <= '0;
              flags_reg.inexact <= (in_data[NM-1:0] != '0);
            end
            CLS_TINY: begin
              out_data_reg      <= '0;
              flags_reg.inexact <= 1'b1;
            end
            CLS_MINNEG: out_data_reg <= INT_MIN;
            CLS_OVF: begin
              out_data_reg       <= sign_in ? INT_MIN : INT_MAX;
              flags_reg.overflow <= 1'b1;
            end
            default: begin
              work_reg <= sig_in;
              k_reg    <= k_in;
              dir_reg  <= dir_in;
              if (k_in == '0) out_data_reg <= idle_res;
            end
          endcase
        end
        SHIFT: begin
          work_reg   <= work_shift;
          sticky_reg <= sticky_next;
          k_reg      <= k_reg - KW'(1);
          if (k_reg == KW'(1)) begin
            out_data_reg      <= shift_res;
            flags_reg.inexact <= sticky_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_flags = flags_reg;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed-vector bench for fp_to_int_seq (NX=8, NM=23, NI=32).
module tb_fp_to_int_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int n_pass = 0;
  int n_checks = 0;

  fp_to_int_seq #(.NX(8), .NM(23), .NI(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one input, waits for the result, then completes the handshake.
  task automatic convert(input logic [31:0] d, output logic [31:0] res,
                         output logic [2:0] fl, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    res = out_data;
    fl  = out_flags;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_data, out_flags} !== {1'b1, 1'b0, 32'h0, 3'b000})
      $display("FAIL reset: rdy=%0b vld=%0b data=%h flags=%b, want rdy=1 vld=0 data=0 flags=000",
               in_ready, out_valid, out_data, out_flags);
    else n_pass++;
  endtask

  task automatic test_vectors();
    vec_t vecs[13];
    logic [31:0] res;
    logic [2:0]  fl;
    int          lat;
    vecs[0]  = '{32'h3F800000, 32'h00000001, 3'b000, 24};
    vecs[1]  = '{32'h4E800001, 32'h40000080, 3'b000, 8};
    vecs[2]  = '{32'hC0200000, 32'hFFFFFFFE, 3'b001, 23};
    vecs[3]  = '{32'h3F400000, 32'h00000000, 3'b001, 1};
    vecs[4]  = '{32'h4F000000, 32'h7FFFFFFF, 3'b010, 1};
    vecs[5]  = '{32'hCF000000, 32'h80000000, 3'b000, 1};
    vecs[6]  = '{32'hCF800000, 32'h80000000, 3'b010, 1};
    vecs[7]  = '{32'h7FC00000, 32'h00000000, 3'b100, 1};
    vecs[8]  = '{32'hFF800000, 32'h80000000, 3'b100, 1};
    vecs[9]  = '{32'h80000000, 32'h00000000, 3'b000, 1};
    vecs[10] = '{32'h4B000000, 32'h00800000, 3'b000, 1};
    vecs[11] = '{32'h00000001, 32'h00000000, 3'b001, 1};
    vecs[12] = '{32'h40400000, 32'h00000003, 3'b000, 23};
    foreach (vecs[i]) begin
      convert(vecs[i].d, res, fl, lat);
      n_checks++;
      if (res !== vecs[i].r)
        $display("FAIL data in=%h: got %h want %h", vecs[i].d, res, vecs[i].r);
      else n_pass++;
      n_checks++;
      if (fl !== vecs[i].f)
        $display("FAIL flags in=%h: got %b want %b", vecs[i].d, fl, vecs[i].f);
      else n_pass++;
      n_checks++;
      if (lat != vecs[i].lat)
        $display("FAIL latency in=%h: got %0d want %0d", vecs[i].d, lat, vecs[i].lat);
      else n_pass++;
      $display("vec %h -> data %h flags %b latency %0d", vecs[i].d, res, fl, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit stable;
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    tick();
    repeat (3) tick();
    in_data = 32'h40400000;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", in_ready);
    else n_pass++;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL bp_done: out_valid got %b want 1", out_valid);
    else n_pass++;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (out_data !== 32'h1 || out_flags !== 3'b000 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
      tick();
    end
    n_checks++;
    if (!stable || out_data !== 32'h1)
      $display("FAIL bp_hold: data=%h flags=%b rdy=%b, want data=00000001 flags=000 rdy=0",
               out_data, out_flags, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_handshake: rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_accept: in_ready got %b want 0", in_ready);
    else n_pass++;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    n_checks++;
    if (out_data !== 32'h3 || lat != 23)
      $display("FAIL bp_second: data=%h latency=%0d want 00000003 latency 23", out_data, lat);
    else n_pass++;
    $display("back_to_back second result %h latency %0d", out_data, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] res;
    logic [2:0]  fl;
    int          lat;
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL mid_reset: rdy=%b vld=%b data=%h want rdy=1 vld=0 data=0",
               in_ready, out_valid, out_data);
    else n_pass++;
    convert(32'h40400000, res, fl, lat);
    n_checks++;
    if (res !== 32'h3 || fl !== 3'b000 || lat != 23)
      $display("FAIL after_reset: data=%h flags=%b latency=%0d want 00000003 000 23", res, fl, lat);
    else n_pass++;
    $display("after reset 40400000 -> %h flags %b latency %0d", res, fl, lat);
  endtask

  initial begin
    #1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
